// File: rtl/mem_port_arbiter.sv
// Two-port (CPU / DMA) arbiter for a single synchronous-read memory, two-cycle issue/response.
// Define MEM_ARB_RR_EN for round-robin; default is fixed CPU priority with a MAX_WAIT anti-starvation counter.
module mem_port_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

`ifndef MEM_ARB_RR_EN
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
`endif

    state_t     state_r;
    logic       owner_r;
    logic       is_read_r;
    logic       last_owner_r;
    logic [3:0] wait_cnt_r;

    logic       any_req_s;
    logic       dma_win_s;
    logic       owner_ok_s;

    // Arbitration decision for the current cycle (used only in IDLE and RESP)
    always_comb begin
        any_req_s = cpu_req | dma_req;
        dma_win_s = 1'b0;
        if (cpu_req && dma_req) begin
`ifdef MEM_ARB_RR_EN
            dma_win_s = (last_owner_r == OWN_CPU);
`else
            dma_win_s = (wait_cnt_r >= MAX_WAIT_C);
`endif
        end else begin
            dma_win_s = dma_req;
        end
    end

    // Sequencer: state, owner, access type, round-robin history and starvation counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWN_CPU;
            is_read_r    <= 1'b0;
            last_owner_r <= OWN_DMA;
            wait_cnt_r   <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_RESP: begin
                    if (any_req_s) begin
                        state_r      <= ST_ISSUE;
                        owner_r      <= dma_win_s;
                        last_owner_r <= dma_win_s;
                        is_read_r    <= dma_win_s ? ~dma_we : ~cpu_we;
`ifdef MEM_ARB_RR_EN
                        wait_cnt_r   <= 4'd0;
`else
                        if (dma_win_s) begin
                            wait_cnt_r <= 4'd0;
                        end else if (dma_req && (wait_cnt_r != 4'd15)) begin
                            wait_cnt_r <= wait_cnt_r + 4'd1;
                        end else begin
                            wait_cnt_r <= wait_cnt_r;
                        end
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_RESP;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Once an access is in flight owner and last_owner must agree; a mismatch means corrupted
    // state, so the port outputs are suppressed rather than driving the wrong requester.
    assign owner_ok_s = (owner_r == last_owner_r);

    // Output decode; everything is forced low while reset is asserted
    always_comb begin
        cpu_gnt    = 1'b0;
        cpu_rvalid = 1'b0;
        cpu_rdata  = {DATA_W{1'b0}};
        dma_gnt    = 1'b0;
        dma_rvalid = 1'b0;
        dma_rdata  = {DATA_W{1'b0}};
        mem_addr   = {ADDR_W{1'b0}};
        mem_we     = 1'b0;
        mem_wdata  = {DATA_W{1'b0}};
        busy       = 1'b0;
        if (!reset) begin
            case (state_r)
                ST_ISSUE: begin
                    busy = 1'b1;
                    if (!owner_ok_s) begin
                        busy = 1'b1;
                    end else if (owner_r == OWN_DMA) begin
                        dma_gnt   = 1'b1;
                        mem_addr  = dma_addr;
                        mem_we    = dma_we;
                        mem_wdata = dma_wdata;
                    end else begin
                        cpu_gnt   = 1'b1;
                        mem_addr  = cpu_addr;
                        mem_we    = cpu_we;
                        mem_wdata = cpu_wdata;
                    end
                end
                ST_RESP: begin
                    busy = 1'b1;
                    if (!is_read_r || !owner_ok_s) begin
                        busy = 1'b1;
                    end else if (owner_r == OWN_DMA) begin
                        dma_rvalid = 1'b1;
                        dma_rdata  = mem_rdata;
                    end else begin
                        cpu_rvalid = 1'b1;
                        cpu_rdata  = mem_rdata;
                    end
                end
                ST_IDLE: begin
                    busy = 1'b0;
                end
                default: begin
                    busy = 1'b0;
                end
            endcase
        end else begin
            busy = 1'b0;
        end
    end

endmodule
